// File: rtl/bp_dcache_pkg.sv
// Shared dcache types: opcode encoding, access size, and opcode decode helpers.
package bp_dcache_pkg;

  // opcode[3] = store, opcode[2] = unsigned, opcode[1:0] = access size
  typedef enum logic [3:0] {
    e_dcache_op_lb  = 4'b0000,
    e_dcache_op_lh  = 4'b0001,
    e_dcache_op_lw  = 4'b0010,
    e_dcache_op_ld  = 4'b0011,
    e_dcache_op_lbu = 4'b0100,
    e_dcache_op_lhu = 4'b0101,
    e_dcache_op_lwu = 4'b0110,
    e_dcache_op_sb  = 4'b1000,
    e_dcache_op_sh  = 4'b1001,
    e_dcache_op_sw  = 4'b1010,
    e_dcache_op_sd  = 4'b1011
  } bp_dcache_opcode_e;

  typedef enum logic [1:0] {
    e_byte  = 2'b00,
    e_half  = 2'b01,
    e_word  = 2'b10,
    e_dword = 2'b11
  } bp_dcache_size_e;

  function automatic bp_dcache_size_e decode_size(input logic [3:0] opcode);
    return bp_dcache_size_e'(opcode[1:0]);
  endfunction

  function automatic logic decode_is_store(input logic [3:0] opcode);
    return opcode[3];
  endfunction

  function automatic logic decode_unsigned(input logic [3:0] opcode);
    return opcode[2];
  endfunction

endpackage

// File: rtl/bp_dcache_load_extend.sv
// Combinational byte/half/word/dword select, sign/zero extension and misalign detect.
module bp_dcache_load_extend
  import bp_dcache_pkg::*;
#(
  parameter int unsigned dword_width_p  = 64,
  parameter int unsigned offset_width_p = 3
) (
  input  logic [3:0]                opcode_i,
  input  logic [offset_width_p-1:0] offset_i,
  input  logic [dword_width_p-1:0]  data_i,
  output logic [dword_width_p-1:0]  data_o,
  output logic                      store_o,
  output logic                      misaligned_o
);

  bp_dcache_size_e            size;
  logic                       sign_ext;
  logic [dword_width_p-1:0]   shifted;
  logic [dword_width_p-1:0]   extended;

  // Shift the addressed field down to bit 0, then extend it to full width.
  always_comb begin
    size     = decode_size(opcode_i);
    sign_ext = ~decode_unsigned(opcode_i);
    shifted  = data_i >> {offset_i, 3'b000};
    extended = '0;
    misaligned_o = 1'b0;
    unique case (size)
      e_byte: begin
        extended     = {{(dword_width_p-8){sign_ext & shifted[7]}}, shifted[7:0]};
        misaligned_o = 1'b0;
      end
      e_half: begin
        extended     = {{(dword_width_p-16){sign_ext & shifted[15]}}, shifted[15:0]};
        misaligned_o = offset_i[0];
      end
      e_word: begin
        extended     = {{(dword_width_p-32){sign_ext & shifted[31]}}, shifted[31:0]};
        misaligned_o = |offset_i[1:0];
      end
      e_dword: begin
        extended     = shifted;
        misaligned_o = |offset_i;
      end
      default: begin
        extended     = '0;
        misaligned_o = 1'b0;
      end
    endcase
    store_o = decode_is_store(opcode_i);
    // Stores and misaligned accesses never forward data.
    data_o  = (store_o | misaligned_o) ? '0 : extended;
  end

endmodule

// File: rtl/bp_dcache_load_align.sv
// Load alignment stage: formats each dcache return and buffers it in a
// 2-entry elastic buffer (out_reg + skid_reg) with a registered ready.
// Optional perf counters enabled by defining BP_DCACHE_LOAD_ALIGN_PERF_EN.
module bp_dcache_load_align
  import bp_dcache_pkg::*;
#(
  parameter int unsigned dword_width_p  = 64,
  parameter int unsigned offset_width_p = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [3:0]                opcode_i,
  input  logic [offset_width_p-1:0] offset_i,
  input  logic [dword_width_p-1:0]  data_i,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [dword_width_p-1:0]  data_o,
  output logic                      store_o,
  output logic                      misaligned_o
`ifdef BP_DCACHE_LOAD_ALIGN_PERF_EN
  ,
  output logic [31:0]               load_cnt_o,
  output logic [31:0]               misalign_cnt_o
`endif
);

  logic [dword_width_p-1:0] fmt_data;
  logic                     fmt_store;
  logic                     fmt_misaligned;

  bp_dcache_load_extend #(
    .dword_width_p  (dword_width_p),
    .offset_width_p (offset_width_p)
  ) u_extend (
    .opcode_i     (opcode_i),
    .offset_i     (offset_i),
    .data_i       (data_i),
    .data_o       (fmt_data),
    .store_o      (fmt_store),
    .misaligned_o (fmt_misaligned)
  );

  logic                     out_v_q, out_v_d;
  logic [dword_width_p-1:0] out_data_q, out_data_d;
  logic                     out_store_q, out_store_d;
  logic                     out_mis_q, out_mis_d;
  logic                     skid_v_q, skid_v_d;
  logic [dword_width_p-1:0] skid_data_q, skid_data_d;
  logic                     skid_store_q, skid_store_d;
  logic                     skid_mis_q, skid_mis_d;

  logic accept;
  logic retire;

  assign ready_o      = ~skid_v_q;
  assign v_o          = out_v_q;
  assign data_o       = out_data_q;
  assign store_o      = out_store_q;
  assign misaligned_o = out_mis_q;

  // Buffer next-state: refill out_reg from skid first to keep FIFO order.
  always_comb begin
    accept       = v_i & ready_o;
    retire       = yumi_i & out_v_q;
    out_v_d      = out_v_q;
    out_data_d   = out_data_q;
    out_store_d  = out_store_q;
    out_mis_d    = out_mis_q;
    skid_v_d     = skid_v_q;
    skid_data_d  = skid_data_q;
    skid_store_d = skid_store_q;
    skid_mis_d   = skid_mis_q;
    if (retire) begin
      if (skid_v_q) begin
        // accept is impossible here since ready_o is low
        out_data_d  = skid_data_q;
        out_store_d = skid_store_q;
        out_mis_d   = skid_mis_q;
        skid_v_d    = 1'b0;
      end else if (accept) begin
        out_data_d  = fmt_data;
        out_store_d = fmt_store;
        out_mis_d   = fmt_misaligned;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (accept) begin
      if (out_v_q) begin
        skid_v_d     = 1'b1;
        skid_data_d  = fmt_data;
        skid_store_d = fmt_store;
        skid_mis_d   = fmt_misaligned;
      end else begin
        out_v_d     = 1'b1;
        out_data_d  = fmt_data;
        out_store_d = fmt_store;
        out_mis_d   = fmt_misaligned;
      end
    end
  end

  // Buffer state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_v_q      <= 1'b0;
      out_data_q   <= '0;
      out_store_q  <= 1'b0;
      out_mis_q    <= 1'b0;
      skid_v_q     <= 1'b0;
      skid_data_q  <= '0;
      skid_store_q <= 1'b0;
      skid_mis_q   <= 1'b0;
    end else begin
      out_v_q      <= out_v_d;
      out_data_q   <= out_data_d;
      out_store_q  <= out_store_d;
      out_mis_q    <= out_mis_d;
      skid_v_q     <= skid_v_d;
      skid_data_q  <= skid_data_d;
      skid_store_q <= skid_store_d;
      skid_mis_q   <= skid_mis_d;
    end
  end

`ifdef BP_DCACHE_LOAD_ALIGN_PERF_EN
  logic [31:0] load_cnt_q;
  logic [31:0] misalign_cnt_q;

  // Retirement counters; wrap naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      load_cnt_q     <= '0;
      misalign_cnt_q <= '0;
    end else if (retire) begin
      if (!out_store_q) load_cnt_q <= load_cnt_q + 32'd1;
      if (out_mis_q)    misalign_cnt_q <= misalign_cnt_q + 32'd1;
    end
  end

  assign load_cnt_o     = load_cnt_q;
  assign misalign_cnt_o = misalign_cnt_q;
`endif

endmodule

// File: tb/tb_bp_dcache_load_align.sv
// Self-checking bench: directed test-plan cases plus randomized traffic
// compared against a queue-based reference model.
module tb_bp_dcache_load_align;

  logic        clk;
  logic        reset_i;
  logic        v_i;
  logic        ready_o;
  logic [3:0]  opcode_i;
  logic [2:0]  offset_i;
  logic [63:0] data_i;
  logic        v_o;
  logic        yumi_i;
  logic [63:0] data_o;
  logic        store_o;
  logic        misaligned_o;
`ifdef BP_DCACHE_LOAD_ALIGN_PERF_EN
  logic [31:0] load_cnt_o;
  logic [31:0] misalign_cnt_o;
  int unsigned exp_load_cnt;
  int unsigned exp_mis_cnt;
`endif

  bp_dcache_load_align dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .opcode_i     (opcode_i),
    .offset_i     (offset_i),
    .data_i       (data_i),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .data_o       (data_o),
    .store_o      (store_o),
    .misaligned_o (misaligned_o)
`ifdef BP_DCACHE_LOAD_ALIGN_PERF_EN
    ,
    .load_cnt_o     (load_cnt_o),
    .misalign_cnt_o (misalign_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        store;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference formatting from the architectural rules, one byte at a time.
  function automatic exp_t ref_fmt(input logic [3:0] op, input logic [2:0] off,
                                   input logic [63:0] d);
    exp_t        e;
    int          nbytes;
    logic [63:0] val;
    nbytes  = 1 << op[1:0];
    e.store = op[3];
    e.mis   = (int'(off) % nbytes) != 0;
    val     = '0;
    if (!e.mis) begin
      for (int i = 0; i < nbytes; i++) begin
        val = val | (((d >> (8 * (int'(off) + i))) & 64'hFF) << (8 * i));
      end
      if (!op[2] && nbytes < 8 && val[8*nbytes-1]) begin
        val = val | ~((64'd1 << (8 * nbytes)) - 64'd1);
      end
    end
    e.data = (e.store || e.mis) ? 64'd0 : val;
    return e;
  endfunction

  task automatic check_outputs();
    check_eq("v_o", 64'(v_o), 64'(q.size() > 0));
    check_eq("ready_o", 64'(ready_o), 64'(q.size() < 2));
    if (q.size() > 0) begin
      check_eq("data_o", data_o, q[0].data);
      check_eq("store_o", 64'(store_o), 64'(q[0].store));
      check_eq("misaligned_o", 64'(misaligned_o), 64'(q[0].mis));
    end
`ifdef BP_DCACHE_LOAD_ALIGN_PERF_EN
    check_eq("load_cnt", 64'(load_cnt_o), 64'(exp_load_cnt));
    check_eq("misalign_cnt", 64'(misalign_cnt_o), 64'(exp_mis_cnt));
`endif
  endtask

  // Called at a negedge: drive one cycle, update the model, check at next negedge.
  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] off,
                       input logic [63:0] d, input logic y);
    logic ret;
    logic acc;
    ret = y && (q.size() > 0);
    acc = v && (q.size() < 2);
    if (ret) check_eq("yumi_legal", 64'(v_o), 64'd1);
    v_i      = v;
    opcode_i = op;
    offset_i = off;
    data_i   = d;
    yumi_i   = ret;
    if (ret) begin
`ifdef BP_DCACHE_LOAD_ALIGN_PERF_EN
      if (!q[0].store) exp_load_cnt++;
      if (q[0].mis) exp_mis_cnt++;
`endif
      void'(q.pop_front());
    end
    if (acc) q.push_back(ref_fmt(op, off, d));
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    q.delete();
`ifdef BP_DCACHE_LOAD_ALIGN_PERF_EN
    exp_load_cnt = 0;
    exp_mis_cnt  = 0;
`endif
    check_eq("rst_v_o", 64'(v_o), 64'd0);
    check_eq("rst_ready_o", 64'(ready_o), 64'd1);
    check_eq("rst_data_o", data_o, 64'd0);
    check_eq("rst_store_o", 64'(store_o), 64'd0);
    check_eq("rst_misaligned_o", 64'(misaligned_o), 64'd0);
`ifdef BP_DCACHE_LOAD_ALIGN_PERF_EN
    check_eq("rst_load_cnt", 64'(load_cnt_o), 64'd0);
    check_eq("rst_misalign_cnt", 64'(misalign_cnt_o), 64'd0);
`endif
  endtask

  localparam logic [63:0] D1 = 64'h0011_2233_8055_6677;
  localparam logic [63:0] D2 = 64'h8000_0001_0000_0000;

  initial begin
    logic [3:0]  r_op;
    logic [2:0]  r_off;
    logic [63:0] r_data;
    logic        r_v;
    logic        r_y;
`ifdef BP_DCACHE_LOAD_ALIGN_PERF_EN
    exp_load_cnt = 0;
    exp_mis_cnt  = 0;
`endif
    reset_i  = 1'b1;
    v_i      = 1'b0;
    yumi_i   = 1'b0;
    opcode_i = '0;
    offset_i = '0;
    data_i   = '0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Directed formatting cases, consumer always ready.
    drive(1'b1, 4'b0000, 3'd3, D1, 1'b1);
    check_eq("lb", data_o, 64'hFFFF_FFFF_FFFF_FF80);
    drive(1'b1, 4'b0100, 3'd3, D1, 1'b1);
    check_eq("lbu", data_o, 64'h0000_0000_0000_0080);
    drive(1'b1, 4'b0001, 3'd2, D1, 1'b1);
    check_eq("lh", data_o, 64'hFFFF_FFFF_FFFF_8055);
    drive(1'b1, 4'b0101, 3'd2, D1, 1'b1);
    check_eq("lhu", data_o, 64'h0000_0000_0000_8055);
    drive(1'b1, 4'b0010, 3'd4, D2, 1'b1);
    check_eq("lw", data_o, 64'hFFFF_FFFF_8000_0001);
    drive(1'b1, 4'b0110, 3'd4, D2, 1'b1);
    check_eq("lwu", data_o, 64'h0000_0000_8000_0001);
    drive(1'b1, 4'b0011, 3'd0, D2, 1'b1);
    check_eq("ld", data_o, D2);
    drive(1'b1, 4'b0010, 3'd2, D2, 1'b1);
    check_eq("lw_mis_flag", 64'(misaligned_o), 64'd1);
    check_eq("lw_mis_data", data_o, 64'd0);
    drive(1'b1, 4'b0011, 3'd4, D2, 1'b1);
    check_eq("ld_mis_flag", 64'(misaligned_o), 64'd1);
    drive(1'b1, 4'b1011, 3'd0, D2, 1'b1);
    check_eq("sd_store", 64'(store_o), 64'd1);
    check_eq("sd_data", data_o, 64'd0);
    check_eq("sd_mis", 64'(misaligned_o), 64'd0);
    drive(1'b0, 4'b0000, 3'd0, 64'd0, 1'b1);

    // Backpressure: three back-to-back loads with no consumer.
    drive(1'b1, 4'b0011, 3'd0, 64'h1111_1111_1111_1111, 1'b0);
    drive(1'b1, 4'b0011, 3'd0, 64'h2222_2222_2222_2222, 1'b0);
    check_eq("bp_ready_low", 64'(ready_o), 64'd0);
    drive(1'b1, 4'b0011, 3'd0, 64'h3333_3333_3333_3333, 1'b0);
    check_eq("bp_first_out", data_o, 64'h1111_1111_1111_1111);
    drive(1'b0, 4'b0000, 3'd0, 64'd0, 1'b1);
    check_eq("bp_ready_back", 64'(ready_o), 64'd1);
    check_eq("bp_second_out", data_o, 64'h2222_2222_2222_2222);
    drive(1'b0, 4'b0000, 3'd0, 64'd0, 1'b1);
    check_eq("bp_drained", 64'(v_o), 64'd0);

    // Reset with both entries occupied.
    drive(1'b1, 4'b0000, 3'd1, D1, 1'b0);
    drive(1'b1, 4'b0001, 3'd0, D1, 1'b0);
    check_eq("full_before_reset", 64'(ready_o), 64'd0);
    do_reset();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      r_op   = 4'($urandom);
      r_off  = 3'($urandom);
      r_data = {$urandom, $urandom};
      r_v    = ($urandom_range(0, 3) != 0);
      r_y    = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        drive(r_v, r_op, r_off, r_data, r_y);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
